hs_ram_arbiter: RTL and testbench

- Shares the single-port game work RAM between the game CPU and the hiscore save/restore engine.
- On a hiscore request it pauses the core, waits for a safe window (CPU bus idle during vblank), grants the RAM port to the hiscore engine, then hands the port back and releases the pause.
- Sits between the hiscore module, the game core's RAM port and the top-level pause logic; replaces the direct hs_access-to-pause wiring.

---
 rtl/hs_ram_arbiter.sv | 133 +++++++++++++
 tb/tb_hs_ram_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter between the game CPU and the hiscore engine; pauses the core and
// grants the port during a CPU-idle vblank window. Optional feature macro: HS_TIMEOUT_EN.
module hs_ram_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int IDLE_CYC = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          user_pause,
    input  logic          vblank,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_we,
    output logic          hs_grant,
    input  logic          cpu_en,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          pause_out,
    output logic          busy
`ifdef HS_TIMEOUT_EN
    ,
    output logic          timeout_flag
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_PAUSE, ST_GRANT, ST_DRAIN} state_t;

    localparam logic [3:0] IDLE_MAX = 4'(IDLE_CYC);
    localparam logic [3:0] HOLD_MAX = 4'(HOLD_CYC);

    state_t     state, next_state;
    logic [3:0] idle_cnt, idle_cnt_nxt;
    logic [3:0] hold_cnt, hold_cnt_nxt;
    logic       hs_sel, hs_sel_nxt;
    logic       grant_nxt, pause_nxt;
`ifdef HS_TIMEOUT_EN
    logic [19:0] wait_cnt, wait_cnt_nxt;
    logic        timeout_hit;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            idle_cnt     <= '0;
            hold_cnt     <= '0;
            hs_sel       <= 1'b0;
            hs_grant     <= 1'b0;
            pause_out    <= 1'b0;
`ifdef HS_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            idle_cnt  <= idle_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            hs_sel    <= hs_sel_nxt;
            hs_grant  <= grant_nxt;
            pause_out <= pause_nxt;
`ifdef HS_TIMEOUT_EN
            wait_cnt     <= wait_cnt_nxt;
            timeout_flag <= timeout_flag | (timeout_hit && next_state == ST_GRANT);
`endif
        end
    end

    // Counters are held at zero outside their own state, so entry always starts from zero.
    always_comb begin
        next_state   = state;
        idle_cnt_nxt = '0;
        hold_cnt_nxt = '0;
`ifdef HS_TIMEOUT_EN
        wait_cnt_nxt = '0;
        timeout_hit  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (hs_req) next_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                idle_cnt_nxt = cpu_en ? '0 :
                               (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 4'd1;
`ifdef HS_TIMEOUT_EN
                wait_cnt_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 20'd1;
                timeout_hit  = (wait_cnt == '1);
                if (!hs_req)
                    next_state = ST_DRAIN;
                else if ((idle_cnt == IDLE_MAX && vblank) || timeout_hit)
                    next_state = ST_GRANT;
`else
                if (!hs_req)
                    next_state = ST_DRAIN;
                else if (idle_cnt == IDLE_MAX && vblank)
                    next_state = ST_GRANT;
`endif
            end
            ST_GRANT: begin
                if (!hs_req) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                hold_cnt_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 4'd1;
                if (hold_cnt == HOLD_MAX) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Registered-output next values: the mux select lingers in DRAIN only if it was switched.
    always_comb begin
        grant_nxt  = (next_state == ST_GRANT);
        pause_nxt  = user_pause | (next_state != ST_IDLE);
        hs_sel_nxt = 1'b0;
        if (next_state == ST_GRANT)
            hs_sel_nxt = 1'b1;
        else if (next_state == ST_DRAIN)
            hs_sel_nxt = hs_sel && (hold_cnt_nxt < HOLD_MAX);
    end

    always_comb begin
        ram_addr  = hs_sel ? hs_addr  : cpu_addr;
        ram_wdata = hs_sel ? hs_wdata : cpu_wdata;
        ram_we    = hs_sel ? (hs_we & hs_grant) : cpu_we;
        busy      = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed phases with randomized traffic for hs_ram_arbiter, checked every cycle
// against a phase-level reference model of the arbitration rules.
module tb_hs_ram_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 8;
    localparam int IDLE_CYC = 4;
    localparam int HOLD_CYC = 2;

    logic          clk_sys, reset_n, user_pause, vblank, hs_req, hs_we, cpu_en, cpu_we;
    logic [AW-1:0] hs_addr, cpu_addr, ram_addr;
    logic [DW-1:0] hs_wdata, cpu_wdata, ram_wdata;
    logic          hs_grant, ram_we, pause_out, busy;
`ifdef HS_TIMEOUT_EN
    logic          timeout_flag;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: who owns the port and where the transfer stands.
    bit m_busy, m_grant, m_sel, m_pause, m_draining;
    int m_idle_run, m_drain_age;

    hs_ram_arbiter #(.AW(AW), .DW(DW), .IDLE_CYC(IDLE_CYC), .HOLD_CYC(HOLD_CYC)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .user_pause(user_pause), .vblank(vblank),
        .hs_req(hs_req), .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_we(hs_we),
        .hs_grant(hs_grant), .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .pause_out(pause_out), .busy(busy)
`ifdef HS_TIMEOUT_EN
        , .timeout_flag(timeout_flag)
`endif
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_grant = 0; m_sel = 0; m_pause = 0; m_draining = 0;
        m_idle_run = 0; m_drain_age = 0;
    endtask

    // Advances the model by one clock using the inputs that were stable before the edge.
    task automatic model_step();
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (hs_req) begin m_busy = 1; m_idle_run = 0; end
        end else if (m_draining) begin
            if (m_drain_age == HOLD_CYC) begin
                m_busy = 0; m_draining = 0;
            end else begin
                m_drain_age++;
                if (m_drain_age >= HOLD_CYC) m_sel = 0;
            end
        end else if (m_grant) begin
            if (!hs_req) begin m_grant = 0; m_draining = 1; m_drain_age = 0; end
        end else begin
            if (!hs_req) begin
                m_draining = 1; m_drain_age = 0;
            end else if (m_idle_run >= IDLE_CYC && vblank) begin
                m_grant = 1; m_sel = 1;
            end else begin
                m_idle_run = cpu_en ? 0 : m_idle_run + 1;
            end
        end
        m_pause = user_pause | m_busy;
    endtask

    task automatic check_all();
        chk("hs_grant",  32'(hs_grant),  32'(m_grant));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("pause_out", 32'(pause_out), 32'(m_pause));
        chk("ram_addr",  32'(ram_addr),  32'(m_sel ? hs_addr : cpu_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(m_sel ? hs_wdata : cpu_wdata));
        chk("ram_we",    32'(ram_we),    32'(m_sel ? (hs_we & m_grant) : cpu_we));
    endtask

    task automatic cycle();
        @(posedge clk_sys);
        model_step();
        @(negedge clk_sys);
        check_all();
    endtask

    task automatic rand_data();
        hs_addr   = AW'($urandom);
        hs_wdata  = DW'($urandom);
        cpu_addr  = AW'($urandom);
        cpu_wdata = DW'($urandom);
        cpu_we    = 1'($urandom);
        hs_we     = 1'($urandom);
    endtask

    initial begin
        int n;
        reset_n = 0; user_pause = 0; vblank = 0; hs_req = 0; cpu_en = 0;
        rand_data();
        model_reset();
        #1;
        chk("reset_grant", 32'(hs_grant), 32'd0);
        chk("reset_busy",  32'(busy),     32'd0);
        chk("reset_sel",   32'(ram_addr), 32'(cpu_addr));
        repeat (2) cycle();
        reset_n = 1;

        // Idle traffic: RAM tracks CPU, no pause.
        for (int i = 0; i < 20; i++) begin
            rand_data();
            cpu_en = 1'($urandom);
            cycle();
        end
        chk("t1_pause", 32'(pause_out), 32'd0);

        // Request with CPU idle and vblank high: grant IDLE_CYC+1 cycles after pause entry.
        hs_req = 1; cpu_en = 0; vblank = 1; hs_we = 0;
        cycle();
        chk("t2_pause_entry", 32'(pause_out), 32'd1);
        n = 0;
        while (!hs_grant && n < 20) begin cycle(); n++; end
        chk("t2_grant_latency", 32'(n), 32'(IDLE_CYC + 1));
        hs_addr = 16'h1234; hs_wdata = 8'hA5; hs_we = 1;
        #1;
        chk("t2_ram_addr",  32'(ram_addr),  32'h1234);
        chk("t2_ram_wdata", 32'(ram_wdata), 32'hA5);
        chk("t2_ram_we",    32'(ram_we),    32'd1);
        @(negedge clk_sys);
        hs_req = 0;
        repeat (HOLD_CYC + 3) cycle();

        // Long wait outside vblank: no grant, CPU keeps the port.
        hs_req = 1; vblank = 0;
        for (int i = 0; i < 1000; i++) begin
            rand_data();
            cpu_en = 1'($urandom);
            cycle();
        end
        chk("t3_no_grant", 32'(hs_grant), 32'd0);
        vblank = 1; cpu_en = 0;
        n = 0;
        while (!hs_grant && n < 10) begin cycle(); n++; end
        chk("t3_grant_within5", 32'(hs_grant == 1'b1 && n <= 5), 32'd1);

        // Release: CPU writes blocked in GRANT, hs address held HOLD_CYC cycles.
        hs_addr = AW'($urandom); cpu_addr = ~hs_addr; hs_we = 0; cpu_we = 1;
        repeat (2) cycle();
        chk("t4_cpu_we_blocked", 32'(ram_we), 32'd0);
        hs_req = 0;
        cycle();
        chk("t4_grant_drop", 32'(hs_grant), 32'd0);
        chk("t4_hold1_addr", 32'(ram_addr), 32'(hs_addr));
        chk("t4_hold1_we",   32'(ram_we),   32'd0);
        cycle();
        chk("t4_hold2_addr", 32'(ram_addr), 32'(hs_addr));
        cycle();
        chk("t4_cpu_addr",   32'(ram_addr),  32'(cpu_addr));
        chk("t4_still_paused", 32'(pause_out), 32'd1);
        cycle();
        chk("t4_unpaused",   32'(pause_out), 32'd0);
        chk("t4_idle",       32'(busy),      32'd0);

        // Reset in GRANT: asynchronous drop to CPU select, then re-serve the held request.
        hs_req = 1; cpu_en = 0; vblank = 1; cpu_we = 0;
        repeat (IDLE_CYC + 3) cycle();
        chk("t5_in_grant", 32'(hs_grant), 32'd1);
        #2;
        reset_n = 0;
        #1;
        model_reset();
        chk("t5_async_grant", 32'(hs_grant), 32'd0);
        chk("t5_async_sel",   32'(ram_addr), 32'(cpu_addr));
        chk("t5_async_busy",  32'(busy),     32'd0);
        repeat (2) cycle();
        reset_n = 1;
        cycle();
        chk("t5_reenter", 32'(busy), 32'd1);

        // Random arbitration traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            cpu_en = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 39) == 0) hs_req = ~hs_req;
            if ($urandom_range(0, 19) == 0) vblank = ~vblank;
            if ($urandom_range(0, 99) == 0) user_pause = ~user_pause;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
